// File: rtl/joybus_poll_ctrl.sv
// joybus_poll_ctrl: probes one N64 controller port, then polls it periodically and latches buttons/stick.
// Optional JOYBUS_RETRY_EN: re-issues a timed-out poll once before declaring the controller gone.
module joybus_poll_ctrl #(
    parameter int          POLL_PERIOD   = 200000,
    parameter int          RSP_TIMEOUT   = 25000,
    parameter int          PROBE_BACKOFF = 500000,
    parameter logic [15:0] DEV_ID        = 16'h0500
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cmd_rdy,
    output logic [7:0]  cmd_data,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [31:0] rx_data,
    output logic        present,
    output logic [13:0] btn,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        upd,
    output logic        overrun
);
    localparam logic [2:0] PROBE   = 3'd0;
    localparam logic [2:0] P_TX    = 3'd1;
    localparam logic [2:0] P_RX    = 3'd2;
    localparam logic [2:0] BACKOFF = 3'd3;
    localparam logic [2:0] IDLE    = 3'd4;
    localparam logic [2:0] Q_TX    = 3'd5;
    localparam logic [2:0] Q_RX    = 3'd6;
    localparam logic [2:0] UPDATE  = 3'd7;
    // One counter serves both the response timeout and the probe backoff.
    localparam int CMAX = (RSP_TIMEOUT > PROBE_BACKOFF) ? RSP_TIMEOUT : PROBE_BACKOFF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_PERIOD);
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] timer;
    logic          poll_tick;
    logic          rsp_to;
    logic          bo_done;
    logic          id_ok;
    logic          retry_ok;
    assign poll_tick = present && timer == PW'(POLL_PERIOD - 1);
    assign rsp_to    = cnt == CW'(RSP_TIMEOUT - 1);
    assign bo_done   = cnt == CW'(PROBE_BACKOFF - 1);
    assign id_ok     = rx_data[23:8] == DEV_ID;
`ifdef JOYBUS_RETRY_EN
    logic retried;
    assign retry_ok = !retried;
    always_ff @(posedge clk)
        retried <= (rst || state == UPDATE || state == BACKOFF) ? 1'b0 :
                   (state == Q_RX && !rx_done && rsp_to) ? 1'b1 : retried;
`else
    assign retry_ok = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PROBE;
            cnt      <= '0;
            timer    <= '0;
            cmd_rdy  <= 1'b0;
            cmd_data <= '0;
            present  <= 1'b0;
            btn      <= '0;
            stick_x  <= '0;
            stick_y  <= '0;
            upd      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            cmd_rdy <= 1'b0;
            upd     <= 1'b0;
            cnt     <= (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
            timer   <= (!present || poll_tick) ? '0 : timer + 1'b1;
            if (poll_tick && (state == Q_TX || state == Q_RX || state == UPDATE))
                overrun <= 1'b1;
            case (state)
                PROBE: begin
                    cmd_rdy  <= 1'b1;
                    cmd_data <= 8'h00;
                    state    <= P_TX;
                end
                P_TX: if (tx_done) begin
                    state <= P_RX;
                    cnt   <= '0;
                end
                P_RX: if (rx_done && id_ok) begin
                    present <= 1'b1;
                    state   <= IDLE;
                end else if (rx_done || rsp_to) begin
                    state <= BACKOFF;
                    cnt   <= '0;
                end
                BACKOFF: if (bo_done) state <= PROBE;
                IDLE: if (poll_tick) begin
                    cmd_rdy  <= 1'b1;
                    cmd_data <= 8'h01;
                    state    <= Q_TX;
                end
                Q_TX: if (tx_done) begin
                    state <= Q_RX;
                    cnt   <= '0;
                end
                Q_RX: if (rx_done) begin
                    btn     <= {rx_data[31:24], rx_data[21:16]};
                    stick_x <= rx_data[15:8];
                    stick_y <= rx_data[7:0];
                    upd     <= 1'b1;
                    state   <= UPDATE;
                end else if (rsp_to && retry_ok) begin
                    cmd_rdy  <= 1'b1;
                    cmd_data <= 8'h01;
                    state    <= Q_TX;
                end else if (rsp_to) begin
                    present <= 1'b0;
                    btn     <= '0;
                    stick_x <= '0;
                    stick_y <= '0;
                    state   <= BACKOFF;
                    cnt     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_joybus_poll_ctrl.sv
// tb_joybus_poll_ctrl: directed sequence with randomized payloads and delays, checked against a transaction-level model.
module tb_joybus_poll_ctrl;
    localparam int P  = 40;
    localparam int R  = 12;
    localparam int PB = 30;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [31:0] rx_data = '0;
    logic        cmd_rdy;
    logic [7:0]  cmd_data;
    logic        present;
    logic [13:0] btn;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        upd;
    logic        overrun;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          upd_cnt = 0;
    int          exp_upd = 0;
    logic        outstanding = 1'b0;
    logic        double_cmd = 1'b0;
    logic [13:0] exp_btn = '0;
    logic [7:0]  exp_x = '0;
    logic [7:0]  exp_y = '0;
    int          last_poll = 0;
    logic        have_last = 1'b0;

    joybus_poll_ctrl #(.POLL_PERIOD(P), .RSP_TIMEOUT(R), .PROBE_BACKOFF(PB), .DEV_ID(16'h0500)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data), .tx_done(tx_done),
        .rx_done(rx_done), .rx_data(rx_data), .present(present), .btn(btn), .stick_x(stick_x),
        .stick_y(stick_y), .upd(upd), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // A new command while the previous one has not seen tx_done is a protocol violation.
    always @(negedge clk) begin
        if (rst) outstanding <= 1'b0;
        else begin
            if (cmd_rdy && outstanding) double_cmd <= 1'b1;
            if (cmd_rdy) outstanding <= 1'b1;
            else if (tx_done) outstanding <= 1'b0;
        end
        if (upd) upd_cnt <= upd_cnt + 1;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!cmd_rdy && n < 4 * P + PB + R) begin step(); n++; end
        chk("cmd_rdy_seen", {31'd0, cmd_rdy}, 1);
    endtask

    task automatic send_tx(input int d);
        step();
        step(d);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic send_rx(input int d, input logic [31:0] v);
        step(d);
        rx_done = 1'b1;
        rx_data = v;
        step();
        rx_done = 1'b0;
    endtask

    task automatic do_poll(input logic [31:0] v, input int rxd, output int n);
        wait_cmd(n);
        chk("poll_cmd", cmd_data, 8'h01);
        if (have_last) chk("poll_gap", cyc - last_poll, P);
        last_poll = cyc;
        have_last = 1'b1;
        send_tx($urandom_range(0, 3));
        send_rx(rxd, v);
        exp_btn = {v[31:24], v[21:16]};
        exp_x = v[15:8];
        exp_y = v[7:0];
        exp_upd++;
        chk("btn", btn, exp_btn);
        chk("stick_x", stick_x, exp_x);
        chk("stick_y", stick_y, exp_y);
        chk("upd_hi", upd, 1);
        chk("present_poll", present, 1);
        step();
        chk("upd_lo", upd, 0);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        step(2);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_present", present, 0);
        chk("rst_btn", btn, 0);
        chk("rst_stick", {stick_x, stick_y}, 0);
        chk("rst_upd", upd, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        wait_cmd(n);
        chk("probe_lat", n, 1);
        chk("probe_cmd", cmd_data, 8'h00);
        send_tx($urandom_range(0, 3));
        send_rx($urandom_range(0, R - 2), 32'h00050002);
        chk("present_up", present, 1);
        do_poll(32'h80207F81, 2, n);
        chk("first_poll_gap", n, P);
        chk("btn_A", btn[13], 1);
        for (int i = 0; i < 6; i++) do_poll($urandom, $urandom_range(0, R - 2), n);
        do_poll($urandom, R - 1, n);
        chk("overrun_quiet", overrun, 0);
        rx_done = 1'b1;
        rx_data = $urandom;
        step();
        rx_done = 1'b0;
        step();
        chk("stray_rx_btn", btn, exp_btn);
        chk("stray_rx_upd", upd_cnt, exp_upd);
        wait_cmd(n);
        chk("to_cmd", cmd_data, 8'h01);
        send_tx(0);
        step(R - 1);
        chk("pre_timeout", present, 1);
        step();
        exp_btn = '0; exp_x = '0; exp_y = '0; have_last = 1'b0;
        chk("to_present", present, 0);
        chk("to_btn", btn, exp_btn);
        chk("to_stick", {stick_x, stick_y}, {exp_x, exp_y});
        wait_cmd(n);
        chk("backoff_len", n, PB + 1);
        chk("reprobe_cmd", cmd_data, 8'h00);
        v = $urandom;
        v[23:8] = 16'h0001;
        send_tx(1);
        send_rx(2, v);
        chk("bad_id_present", present, 0);
        wait_cmd(n);
        chk("bad_id_backoff", n, PB + 1);
        chk("bad_id_reprobe", cmd_data, 8'h00);
        v = $urandom;
        v[23:8] = 16'h0500;
        send_tx(0);
        send_rx(0, v);
        chk("reprobe_present", present, 1);
        do_poll($urandom, $urandom_range(0, R - 1), n);
        chk("reprobe_poll_gap", n, P);
        wait_cmd(n);
        chk("ovr_cmd", cmd_data, 8'h01);
        send_tx(P + 5);
        chk("overrun_set", overrun, 1);
        v = $urandom;
        send_rx(1, v);
        exp_upd++;
        chk("ovr_btn", btn, {v[31:24], v[21:16]});
        step();
        have_last = 1'b0;
        chk("no_double_cmd", double_cmd, 0);
        wait_cmd(n);
        send_tx(0);
        step(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rx_done = 1'b1;
        rx_data = $urandom;
        step();
        rx_done = 1'b0;
        chk("rst_mid_present", present, 0);
        chk("rst_mid_btn", btn, 0);
        chk("rst_mid_stick", {stick_x, stick_y}, 0);
        chk("rst_mid_overrun", overrun, 0);
        chk("rst_mid_upd", upd, 0);
        chk("rst_mid_cmd", {cmd_rdy, cmd_data}, 9'h100);
        step(3);
        chk("upd_count", upd_cnt, exp_upd);
        chk("no_double_cmd_end", double_cmd, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
